// File: rtl/uart_pkg.sv
// Shared types for the uart_rxd controller: FSM states, error bit
// positions and the receiver configuration record.
package uart_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        QUIESCE  = 2'd2,
        LOAD     = 2'd3
    } state_t;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;

    typedef struct packed {
        logic [1:0] parity;
        logic [1:0] sample;
        logic       stop;
        logic       enable;
    } cfg_t;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO. Pushes are ignored when full and pops when
// empty. The level carries one extra bit so full and empty differ.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [7:0]             i_data,
    input  logic                   i_pop,
    output logic [7:0]             o_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage array; no reset needed since reads are qualified by level.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rxd_ctrl.sv
// Receiver controller: owns the active uart_rxd configuration and enable,
// applies staged host changes only when the line is idle (or after a
// timeout), buffers received bytes and keeps error/overrun status.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DISABLED | receiver off; any pending change goes straight to LOAD
// RUN      | receiver on with active config; pending change -> QUIESCE
// QUIESCE  | receiver still on, waiting for idle line or dwell timeout
// LOAD     | one cycle with receiver off while staging becomes active
module uart_rxd_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int IDLE_CYCLES    = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DROP_ERR       = 0
) (
    input  logic                   i_uart_clk,
    input  logic                   i_rst,
    input  logic                   i_cfg_wr,
    input  logic [1:0]             i_cfg_parity,
    input  logic [1:0]             i_cfg_sample,
    input  logic                   i_cfg_stop,
    input  logic                   i_cfg_enable,
    input  logic                   i_clr_status,
    input  logic                   i_rxd,
    output logic                   o_enable,
    output logic [1:0]             o_cfg_rxd_parity,
    output logic [1:0]             o_cfg_rxd_sample,
    output logic                   o_cfg_rxd_stop,
    output logic                   o_fifo_notfull,
    input  logic                   i_fifo_wr,
    input  logic [7:0]             i_fifo_data,
    input  logic [1:0]             i_error,
    output logic [7:0]             o_rd_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [7:0]             o_par_err_cnt,
    output logic [7:0]             o_frm_err_cnt,
    output logic                   o_overrun,
    output logic                   o_forced,
    output logic                   o_busy
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
    localparam logic [TW-1:0] DWELL_MAX = TW'(TIMEOUT_CYCLES);

    state_t        r_state;
    cfg_t          r_stage;
    cfg_t          r_active;
    logic          r_pending;
    logic          r_enable;
    logic          r_forced;
    logic [IW-1:0] r_idle;
    logic [TW-1:0] r_dwell;
    logic [7:0]    r_par_cnt;
    logic [7:0]    r_frm_cnt;
    logic          r_overrun;

    logic          w_pending;
    logic [IW-1:0] w_idle_next;
    logic [TW-1:0] w_dwell_next;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic [7:0]    w_par_base;
    logic [7:0]    w_frm_base;

    // A strobe in the current cycle counts as pending so DISABLED reaches
    // LOAD on the same edge that captures the staging registers.
    assign w_pending    = r_pending || i_cfg_wr;
    assign w_idle_next  = i_rxd ? (r_idle + IW'(1)) : '0;
    assign w_dwell_next = r_dwell + TW'(1);

    // Host staging: last write wins; LOAD consumes it unless re-written.
    always_ff @(posedge i_uart_clk) begin
        if (i_rst) begin
            r_stage   <= '0;
            r_pending <= 1'b0;
        end else if (i_cfg_wr) begin
            r_stage   <= '{parity: i_cfg_parity, sample: i_cfg_sample,
                           stop: i_cfg_stop, enable: i_cfg_enable};
            r_pending <= 1'b1;
        end else if (r_state == LOAD) begin
            r_pending <= 1'b0;
        end
    end

    // Sequencing FSM with registered enable, active config and forced flag.
    always_ff @(posedge i_uart_clk) begin
        if (i_rst) begin
            r_state  <= DISABLED;
            r_enable <= 1'b0;
            r_active <= '0;
            r_forced <= 1'b0;
            r_idle   <= '0;
            r_dwell  <= '0;
        end else begin
            case (r_state)
                DISABLED: begin
                    r_enable <= 1'b0;
                    if (w_pending) begin
                        r_state <= LOAD;
                    end
                end
                RUN: begin
                    if (w_pending) begin
                        r_state <= QUIESCE;
                        r_idle  <= '0;
                        r_dwell <= '0;
                    end
                end
                QUIESCE: begin
                    r_idle  <= w_idle_next;
                    r_dwell <= w_dwell_next;
                    if (w_idle_next == IDLE_MAX) begin
                        r_state  <= LOAD;
                        r_enable <= 1'b0;
                    end else if (w_dwell_next == DWELL_MAX) begin
                        r_state  <= LOAD;
                        r_enable <= 1'b0;
                        r_forced <= 1'b1;
                    end
                end
                LOAD: begin
                    r_active <= r_stage;
                    r_enable <= r_stage.enable;
                    r_state  <= r_stage.enable ? RUN : DISABLED;
                end
                default: begin
                    r_state  <= DISABLED;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    // Clear is applied before the same-cycle increment.
    assign w_par_base = i_clr_status ? 8'd0 : r_par_cnt;
    assign w_frm_base = i_clr_status ? 8'd0 : r_frm_cnt;

    // Saturating error counters and sticky overrun.
    always_ff @(posedge i_uart_clk) begin
        if (i_rst) begin
            r_par_cnt <= 8'd0;
            r_frm_cnt <= 8'd0;
            r_overrun <= 1'b0;
        end else begin
            r_par_cnt <= (i_fifo_wr && i_error[ERR_PARITY]) ? sat_inc(w_par_base) : w_par_base;
            r_frm_cnt <= (i_fifo_wr && i_error[ERR_FRAME])  ? sat_inc(w_frm_base) : w_frm_base;
            r_overrun <= (i_fifo_wr && w_full) || (r_overrun && !i_clr_status);
        end
    end

    assign w_push = i_fifo_wr && !((DROP_ERR != 0) && (i_error != 2'b00));

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_uart_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_fifo_data),
        .i_pop   (i_rd_ready),
        .o_data  (o_rd_data),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_enable         = r_enable;
    assign o_cfg_rxd_parity = r_active.parity;
    assign o_cfg_rxd_sample = r_active.sample;
    assign o_cfg_rxd_stop   = r_active.stop;
    assign o_fifo_notfull   = !w_full;
    assign o_rd_valid       = !w_empty;
    assign o_par_err_cnt    = r_par_cnt;
    assign o_frm_err_cnt    = r_frm_cnt;
    assign o_overrun        = r_overrun;
    assign o_forced         = r_forced;
    assign o_busy           = r_pending || (r_state == QUIESCE) || (r_state == LOAD);

endmodule

// File: tb/tb_uart_rxd_ctrl.sv
// Bench for uart_rxd_ctrl: directed config sequencing plus a queue-based
// FIFO/status reference model with a separate pop-side monitor.
module tb_uart_rxd_ctrl;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_cfg_wr = 1'b0;
    logic [1:0] i_cfg_parity = '0;
    logic [1:0] i_cfg_sample = '0;
    logic       i_cfg_stop = 1'b0;
    logic       i_cfg_enable = 1'b0;
    logic       i_clr_status = 1'b0;
    logic       i_rxd = 1'b1;
    logic       i_fifo_wr = 1'b0;
    logic [7:0] i_fifo_data = '0;
    logic [1:0] i_error = '0;
    logic       i_rd_ready = 1'b0;

    logic       o_enable, o_cfg_rxd_stop, o_fifo_notfull, o_rd_valid;
    logic [1:0] o_cfg_rxd_parity, o_cfg_rxd_sample;
    logic [7:0] o_rd_data, o_par_err_cnt, o_frm_err_cnt;
    logic [4:0] o_level;
    logic       o_overrun, o_forced, o_busy;

    logic       d2_enable, d2_stop, d2_notfull, d2_valid;
    logic [1:0] d2_parity, d2_sample;
    logic [7:0] d2_data, d2_par, d2_frm;
    logic [4:0] d2_level;
    logic       d2_overrun, d2_forced, d2_busy;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int mon_pops = 0;

    // reference model state
    int       m_level = 0;
    int       m2_level = 0;
    int       m_par = 0;
    int       m_frm = 0;
    bit       m_ovr = 1'b0;
    bit [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rxd_ctrl #(.DEPTH(DEPTH), .DROP_ERR(0)) dut (
        .i_uart_clk(clk), .i_rst(i_rst), .i_cfg_wr(i_cfg_wr),
        .i_cfg_parity(i_cfg_parity), .i_cfg_sample(i_cfg_sample),
        .i_cfg_stop(i_cfg_stop), .i_cfg_enable(i_cfg_enable),
        .i_clr_status(i_clr_status), .i_rxd(i_rxd),
        .o_enable(o_enable), .o_cfg_rxd_parity(o_cfg_rxd_parity),
        .o_cfg_rxd_sample(o_cfg_rxd_sample), .o_cfg_rxd_stop(o_cfg_rxd_stop),
        .o_fifo_notfull(o_fifo_notfull), .i_fifo_wr(i_fifo_wr),
        .i_fifo_data(i_fifo_data), .i_error(i_error),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_level(o_level), .o_par_err_cnt(o_par_err_cnt),
        .o_frm_err_cnt(o_frm_err_cnt), .o_overrun(o_overrun),
        .o_forced(o_forced), .o_busy(o_busy)
    );

    uart_rxd_ctrl #(.DEPTH(DEPTH), .DROP_ERR(1)) dut_drop (
        .i_uart_clk(clk), .i_rst(i_rst), .i_cfg_wr(i_cfg_wr),
        .i_cfg_parity(i_cfg_parity), .i_cfg_sample(i_cfg_sample),
        .i_cfg_stop(i_cfg_stop), .i_cfg_enable(i_cfg_enable),
        .i_clr_status(i_clr_status), .i_rxd(i_rxd),
        .o_enable(d2_enable), .o_cfg_rxd_parity(d2_parity),
        .o_cfg_rxd_sample(d2_sample), .o_cfg_rxd_stop(d2_stop),
        .o_fifo_notfull(d2_notfull), .i_fifo_wr(i_fifo_wr),
        .i_fifo_data(i_fifo_data), .i_error(i_error),
        .o_rd_data(d2_data), .o_rd_valid(d2_valid), .i_rd_ready(i_rd_ready),
        .o_level(d2_level), .o_par_err_cnt(d2_par),
        .o_frm_err_cnt(d2_frm), .o_overrun(d2_overrun),
        .o_forced(d2_forced), .o_busy(d2_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int p, input int s, input int st, input int en);
        i_cfg_wr     = 1'b1;
        i_cfg_parity = 2'(p);
        i_cfg_sample = 2'(s);
        i_cfg_stop   = 1'(st);
        i_cfg_enable = 1'(en);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " enable"}, int'(o_enable), 0);
        chk({tag, " parity"}, int'(o_cfg_rxd_parity), 0);
        chk({tag, " sample"}, int'(o_cfg_rxd_sample), 0);
        chk({tag, " stop"}, int'(o_cfg_rxd_stop), 0);
        chk({tag, " valid"}, int'(o_rd_valid), 0);
        chk({tag, " level"}, int'(o_level), 0);
        chk({tag, " notfull"}, int'(o_fifo_notfull), 1);
        chk({tag, " par_cnt"}, int'(o_par_err_cnt), 0);
        chk({tag, " frm_cnt"}, int'(o_frm_err_cnt), 0);
        chk({tag, " overrun"}, int'(o_overrun), 0);
        chk({tag, " forced"}, int'(o_forced), 0);
        chk({tag, " busy"}, int'(o_busy), 0);
    endtask

    // Reference model: FIFO occupancy as a queue, counters as integers.
    always @(posedge clk) begin
        bit full, full2, push2, pop1, pop2;
        if (i_rst) begin
            m_level = 0; m2_level = 0; m_par = 0; m_frm = 0; m_ovr = 1'b0;
            exp_q.delete();
        end else begin
            full  = (m_level == DEPTH);
            full2 = (m2_level == DEPTH);
            pop1  = i_rd_ready && (m_level > 0);
            pop2  = i_rd_ready && (m2_level > 0);
            push2 = 1'b0;
            if (i_clr_status) begin
                m_par = 0; m_frm = 0; m_ovr = 1'b0;
            end
            if (i_fifo_wr) begin
                if (i_error[0]) m_par = (m_par < 255) ? m_par + 1 : 255;
                if (i_error[1]) m_frm = (m_frm < 255) ? m_frm + 1 : 255;
                if (full) m_ovr = 1'b1;
                else begin
                    exp_q.push_back(i_fifo_data);
                    m_level++;
                end
                push2 = !full2 && (i_error == 2'b00);
            end
            if (pop1) m_level--;
            m2_level = m2_level + int'(push2) - int'(pop2);
        end
    end

    // Monitor: status every cycle, head data on every accepted pop.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level", int'(o_level), m_level);
            chk("rd_valid", int'(o_rd_valid), int'(m_level > 0));
            chk("notfull", int'(o_fifo_notfull), int'(m_level < DEPTH));
            chk("par_cnt", int'(o_par_err_cnt), m_par);
            chk("frm_cnt", int'(o_frm_err_cnt), m_frm);
            chk("overrun", int'(o_overrun), int'(m_ovr));
            chk("drop_level", int'(d2_level), m2_level);
            if (o_rd_valid && i_rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    chk("rd_data", int'(o_rd_data), int'(exp_q.pop_front()));
                    mon_pops++;
                end
            end
        end
    end

    initial begin
        int pops0;
        // reset
        tick(3);
        mon_en = 1'b1;
        chk_reset_outputs("reset");
        i_rst = 1'b0;

        // boot
        cfg(2, 0, 0, 1);
        tick();
        i_cfg_wr = 1'b0;
        chk("boot enable_early", int'(o_enable), 0);
        chk("boot busy_high", int'(o_busy), 1);
        tick();
        chk("boot enable", int'(o_enable), 1);
        chk("boot parity", int'(o_cfg_rxd_parity), 2);
        chk("boot sample", int'(o_cfg_rxd_sample), 0);
        chk("boot stop", int'(o_cfg_rxd_stop), 0);
        chk("boot busy_low", int'(o_busy), 0);

        // mid-frame change: 20 low cycles, strobe at cycle 5, one byte arrives
        i_rxd = 1'b0;
        tick(5);
        cfg(1, 2, 1, 1);
        tick();
        i_cfg_wr = 1'b0;
        tick(6);
        i_fifo_wr = 1'b1; i_fifo_data = 8'hA5;
        tick();
        i_fifo_wr = 1'b0;
        tick(7);
        chk("mid enable_held", int'(o_enable), 1);
        chk("mid busy", int'(o_busy), 1);
        chk("mid old_parity", int'(o_cfg_rxd_parity), 2);
        i_rxd = 1'b1;
        for (int k = 1; k < 32; k++) begin
            tick();
            chk("mid enable_idle", int'(o_enable), 1);
        end
        tick();
        chk("mid enable_low", int'(o_enable), 0);
        tick();
        chk("mid enable_back", int'(o_enable), 1);
        chk("mid parity", int'(o_cfg_rxd_parity), 1);
        chk("mid sample", int'(o_cfg_rxd_sample), 2);
        chk("mid stop", int'(o_cfg_rxd_stop), 1);
        chk("mid busy_low", int'(o_busy), 0);
        i_rd_ready = 1'b1;
        tick(2);
        i_rd_ready = 1'b0;

        // stuck line forces load after the dwell timeout
        i_rxd = 1'b0;
        cfg(3, 1, 0, 1);
        tick();
        i_cfg_wr = 1'b0;
        tick(4095);
        chk("stuck enable_held", int'(o_enable), 1);
        chk("stuck forced_early", int'(o_forced), 0);
        tick();
        chk("stuck enable_low", int'(o_enable), 0);
        chk("stuck forced", int'(o_forced), 1);
        tick();
        chk("stuck enable_back", int'(o_enable), 1);
        chk("stuck parity", int'(o_cfg_rxd_parity), 3);
        chk("stuck sample", int'(o_cfg_rxd_sample), 1);
        chk("stuck busy", int'(o_busy), 0);

        // reset during QUIESCE discards the pending change
        cfg(0, 3, 1, 0);
        tick();
        i_cfg_wr = 1'b0;
        tick(10);
        chk("rstq busy", int'(o_busy), 1);
        i_rst = 1'b1;
        tick();
        chk_reset_outputs("rstq");
        i_rst = 1'b0;
        i_rxd = 1'b1;
        tick(50);
        chk("rstq no_load_enable", int'(o_enable), 0);
        chk("rstq no_load_sample", int'(o_cfg_rxd_sample), 0);
        chk("rstq no_load_stop", int'(o_cfg_rxd_stop), 0);
        chk("rstq no_load_busy", int'(o_busy), 0);

        // fill, overrun and drain order
        i_rd_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            i_fifo_wr = 1'b1; i_fifo_data = 8'(k);
            tick();
        end
        i_fifo_wr = 1'b0;
        chk("fill level", int'(o_level), 16);
        chk("fill notfull", int'(o_fifo_notfull), 0);
        chk("fill overrun_clear", int'(o_overrun), 0);
        i_fifo_wr = 1'b1; i_fifo_data = 8'h55;
        tick();
        i_fifo_wr = 1'b0;
        chk("fill overrun", int'(o_overrun), 1);
        chk("fill level_after", int'(o_level), 16);
        pops0 = mon_pops;
        i_rd_ready = 1'b1;
        tick(18);
        chk("drain pops", mon_pops - pops0, 16);
        chk("drain level", int'(o_level), 0);

        // error counters saturate; clear collides with a parity error
        for (int k = 0; k < 300; k++) begin
            i_fifo_wr = 1'b1; i_error = 2'b11; i_fifo_data = 8'($urandom);
            tick();
        end
        i_fifo_wr = 1'b0; i_error = 2'b00;
        chk("err par_sat", int'(o_par_err_cnt), 255);
        chk("err frm_sat", int'(o_frm_err_cnt), 255);
        chk("err drop_level", int'(d2_level), 0);
        i_clr_status = 1'b1; i_fifo_wr = 1'b1; i_error = 2'b01;
        tick();
        i_clr_status = 1'b0; i_fifo_wr = 1'b0; i_error = 2'b00;
        chk("clr par", int'(o_par_err_cnt), 1);
        chk("clr frm", int'(o_frm_err_cnt), 0);
        tick(3);

        // random traffic: slow reader then fast reader
        for (int k = 0; k < 600; k++) begin
            i_fifo_wr    = 1'($urandom_range(0, 1));
            i_fifo_data  = 8'($urandom);
            i_error      = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            i_rd_ready   = (k < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            i_clr_status = ($urandom_range(0, 63) == 0);
            tick();
        end
        i_fifo_wr = 1'b0; i_error = 2'b00; i_clr_status = 1'b0; i_rd_ready = 1'b1;
        tick(20);
        chk("rand drained", exp_q.size(), 0);
        chk("rand level", int'(o_level), 0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rxd_ctrl.md
# uart_rxd_ctrl

Controller sitting between the host/register side and the `uart_rxd` receiver. It owns the receiver's active configuration and enable, and applies host configuration changes only at frame boundaries (line idle). It buffers received bytes in a local FIFO with a valid/ready read port, and keeps saturating parity/framing error counters plus a sticky overrun flag.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of 2, ≥ 2.
- `IDLE_CYCLES`, 32: consecutive `i_rxd`=1 clocks that count as line idle (≥ 1).
- `TIMEOUT_CYCLES`, 4096: maximum QUIESCE dwell before a forced load (> `IDLE_CYCLES`).
- `DROP_ERR`, 0: 1 = bytes flagged with an error are not written to the FIFO.

Ports:
- `i_uart_clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `i_rst`  in  1  synchronous active-high reset.
- `i_cfg_wr`  in  1  one-cycle strobe; captures the four `i_cfg_*` fields into staging.
- `i_cfg_parity`  in  2  requested parity setting.
- `i_cfg_sample`  in  2  requested sample setting.
- `i_cfg_stop`  in  1  requested stop-bit setting.
- `i_cfg_enable`  in  1  requested receiver enable.
- `i_clr_status`  in  1  one-cycle strobe; clears the counters and overrun.
- `i_rxd`  in  1  serial line, monitored for idle (the same net the receiver sees).
- `o_enable`, `o_cfg_rxd_parity[1:0]`, `o_cfg_rxd_sample[1:0]`, `o_cfg_rxd_stop`  out  registered  drive the receiver.
- `o_fifo_notfull`  out  1  to receiver; 1 when level < `DEPTH`.
- `i_fifo_wr`  in  1  receiver byte strobe.
- `i_fifo_data`  in  8  receiver byte.
- `i_error`  in  2  receiver error, qualified by `i_fifo_wr`: bit0 = parity, bit1 = framing.
- `o_rd_data`  out  8  FIFO head.
- `o_rd_valid`  out  1  FIFO not empty.
- `i_rd_ready`  in  1  pop when `o_rd_valid` is 1.
- `o_level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `o_par_err_cnt`, `o_frm_err_cnt`  out  8 each  saturating at 255.
- `o_overrun`  out  1  sticky; set when a write arrives while the FIFO is full.
- `o_forced`  out  1  sticky; set when a QUIESCE timeout forced a load.
- `o_busy`  out  1  1 when a staged change is pending or the FSM is in QUIESCE/LOAD.

## Operation
- Reset values:
  - FSM = DISABLED, so `o_enable`=0.
  - Active config and staging = 0; pending flag = 0.
  - FIFO empty: `o_rd_valid`=0, `o_level`=0, `o_fifo_notfull`=1.
  - Counters = 0; `o_overrun`, `o_forced`, `o_busy` = 0.
- Staging: `i_cfg_wr` overwrites staging and sets pending. A later write before the load replaces the staged values (last write wins).
- FSM transitions:
  - DISABLED: `o_enable`=0. Pending → LOAD.
  - RUN: `o_enable`=1. Pending → QUIESCE.
  - QUIESCE: `o_enable` stays 1, so an in-flight frame completes and is still captured.
    - Idle counter increments on `i_rxd`=1 and clears on `i_rxd`=0.
    - Idle counter reaches `IDLE_CYCLES` → LOAD.
    - Dwell counter reaches `TIMEOUT_CYCLES` → LOAD and set `o_forced`.
  - LOAD (1 cycle): `o_enable`=0; copy staging to active; clear pending. Next state = RUN if staged enable=1, else DISABLED.
  - A `i_cfg_wr` arriving in the LOAD cycle sets pending again; it is handled from the next state.
- FIFO write: on `i_fifo_wr`.
  - Full (judged before any same-cycle pop) → byte dropped, `o_overrun` set.
  - `DROP_ERR`=1 and `i_error`≠0 → byte not written; counters still update.
- Counters: `i_error[0]` increments `o_par_err_cnt`; `i_error[1]` increments `o_frm_err_cnt`. Each saturates at 255.
- Same-cycle clear and increment: clear first, so the result is 1.
- Simultaneous push and pop when not full: both happen, level unchanged.
- Pointers wrap modulo `DEPTH`. The level is kept at `$clog2(DEPTH)+1` bits so full and empty are unambiguous.

## Timing
- `i_fifo_wr` sampled at edge N → `o_rd_valid`/`o_rd_data`/`o_level` updated after edge N.
- A pop at edge N presents the next head after edge N.
- `o_fifo_notfull` is derived from the registered level. It drops the cycle after the write that fills the FIFO.
- Config: `i_cfg_wr` at edge N while DISABLED → LOAD in cycle N+1. Active config and `o_enable` change after edge N+1.
- RUN path: LOAD is entered on the edge where the idle count reaches `IDLE_CYCLES`. `o_enable` is low for exactly one cycle, then returns to the staged value.
- `o_busy` rises after the `i_cfg_wr` edge and falls after the LOAD edge.
- `i_rst` mid-QUIESCE: the staged change is discarded and every output returns to its reset value on the next edge.

## Structure
- Package `uart_pkg`:
  - FSM state enum {DISABLED, RUN, QUIESCE, LOAD}.
  - Error bit positions `ERR_PARITY`=0, `ERR_FRAME`=1.
  - Config struct {parity[1:0], sample[1:0], stop, enable}.
- Sub-module `uart_rx_fifo`: synchronous FIFO, parameter `DEPTH`, 8-bit data, push/pop/level/full/empty.
- FSM, staging, counters and status logic stay in `uart_rxd_ctrl`.

## Test plan
- Boot: after reset, `i_cfg_wr` with parity=2'b10, sample=0, stop=0, enable=1 → `o_enable` rises 2 cycles after the strobe; outputs equal the staged values.
- Mid-frame change: in RUN, drive `i_rxd`=0 for 20 cycles, `i_cfg_wr` at cycle 5 → `o_enable` held until 32 idle cycles after `i_rxd` returns high, then 1-cycle low, new config applied.
- Stuck line: `i_rxd`=0 permanently during QUIESCE → LOAD at cycle 4096, `o_forced`=1.
- Fill/overrun, `DEPTH`=16, `i_rd_ready`=0:
  - 16 writes → `o_level`=16, `o_fifo_notfull`=0.
  - 17th write → dropped, `o_overrun`=1.
  - Drain order matches 0x00..0x0F.
- Errors: 300 writes with `i_error`=2'b11 → both counters = 255. `i_clr_status` coinciding with a parity error → `o_par_err_cnt`=1, `o_frm_err_cnt`=0. With `DROP_ERR`=1, `o_level` stays 0.
- Reset while QUIESCE with a pending change → all outputs at reset values; no load occurs afterwards.
